// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined add/subtract unit.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG_W = 4;

  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Per-stage payload at the default widths; the top declares the same shape at its own WIDTH.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 carry;
    logic                 msb_cin;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } seg_payload_t;

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline stage: resolves segment IDX of the sum and registers the payload.
module adder_seg_stage
  import adder_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  SEG_W = DEF_SEG_W,
  parameter int  IDX   = 0,
  parameter type PL_T  = seg_payload_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv_i,
  input  logic valid_i,
  input  PL_T  pl_i,
  output logic valid_o,
  output PL_T  pl_o
);

  logic             valid_q, valid_d;
  PL_T              pl_q, pl_d;
  logic [SEG_W-1:0] a_seg, b_seg, s_seg;
  logic             c_seg;

  always_comb begin
    a_seg          = pl_i.a[IDX*SEG_W +: SEG_W];
    b_seg          = pl_i.b[IDX*SEG_W +: SEG_W];
    {c_seg, s_seg} = {1'b0, a_seg} + {1'b0, b_seg} + (SEG_W+1)'(pl_i.carry);
    valid_d        = valid_q;
    pl_d           = pl_q;
    if (adv_i) begin
      valid_d                         = valid_i;
      pl_d                            = pl_i;
      pl_d.sum[IDX*SEG_W +: SEG_W]    = s_seg;
      pl_d.carry                      = c_seg;
      // Carry into the segment MSB recovered from its sum bit; only the top stage's copy is used.
      pl_d.msb_cin = a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ s_seg[SEG_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pl_q    <= pl_d;
    end
  end

  assign valid_o = valid_q;
  assign pl_o    = pl_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract with one SEG_W-bit segment resolved per stage and valid/ready flow control.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (SEG_W < 1 || WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of SEG_W");
  end

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             msb_cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pl_t;

  pl_t             pl_in;
  pl_t             pl_out [NSEG];
  logic [NSEG-1:0] valid;
  logic [NSEG-1:0] adv;

  // Subtract folds into an add: invert b and flip the carry once at entry.
  always_comb begin
    pl_in         = '0;
    pl_in.a       = a;
    pl_in.b       = b ^ {WIDTH{sub}};
    pl_in.carry   = cin ^ sub;
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // A stage may advance unless it and every stage below it hold a beat that cannot leave.
    assign adv[k] = out_ready | ~(&valid[NSEG-1:k]);

    if (k == 0) begin : g_first
      adder_seg_stage #(.WIDTH(WIDTH), .SEG_W(SEG_W), .IDX(k), .PL_T(pl_t)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (adv[k]),
        .valid_i (in_valid),
        .pl_i    (pl_in),
        .valid_o (valid[k]),
        .pl_o    (pl_out[k])
      );
    end else begin : g_rest
      adder_seg_stage #(.WIDTH(WIDTH), .SEG_W(SEG_W), .IDX(k), .PL_T(pl_t)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (adv[k]),
        .valid_i (valid[k-1]),
        .pl_i    (pl_out[k-1]),
        .valid_o (valid[k]),
        .pl_o    (pl_out[k])
      );
    end
  end

  assign in_ready  = adv[0] & rst_n;
  assign out_valid = valid[NSEG-1];
  assign s         = pl_out[NSEG-1].sum;
  assign cout      = pl_out[NSEG-1].carry;
  assign ovf       = pl_out[NSEG-1].carry ^ pl_out[NSEG-1].msb_cin;

  logic unused_ok;
  assign unused_ok = ^{pl_out[NSEG-1].a, pl_out[NSEG-1].b};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: table vectors, hand sequences and random traffic against an arithmetic model.
module tb_pipelined_adder;

  localparam int W    = 16;
  localparam int SW   = 4;
  localparam int NSEG = 4;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic         out_valid, out_ready = 1'b0, cout, ovf;
  logic [W-1:0] a = '0, b = '0, s;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .SEG_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  typedef struct { logic [15:0] s; logic cout; logic ovf; } res_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic cin; logic sub; res_t exp; } vec_t;
  typedef struct { res_t r; int t; } sb_t;

  sb_t  q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   chk_lat = 1'b1, acc = 1'b0, held = 1'b0;
  res_t held_r, exp_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain integer arithmetic: unsigned result for s/cout, signed result for overflow.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic sb);
    int   ux, uy, sx, sy, u, sv;
    res_t r;
    ux = {16'b0, x};
    uy = {16'b0, y};
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      u = ux + uy + int'(c);
      sv = sx + sy + int'(c);
      r.cout = (u > 65535);
    end else begin
      u = ux - uy - int'(c);
      sv = sx - sy - int'(c);
      r.cout = (u >= 0);
    end
    r.s   = u[15:0];
    r.ovf = (sv > 32767) || (sv < -32768);
    return r;
  endfunction

  // Called in the low clock phase with inputs set; observes, then crosses one rising edge.
  task automatic cycle();
    sb_t e;
    #1;
    acc = in_valid && in_ready;
    if (held) begin
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_s", {16'b0, s}, {16'b0, held_r.s});
      check("hold_cout", {31'b0, cout}, {31'b0, held_r.cout});
      check("hold_ovf", {31'b0, ovf}, {31'b0, held_r.ovf});
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        check("s", {16'b0, s}, {16'b0, e.r.s});
        check("cout", {31'b0, cout}, {31'b0, e.r.cout});
        check("ovf", {31'b0, ovf}, {31'b0, e.r.ovf});
        if (chk_lat) check("latency", cyc - e.t, NSEG);
      end
    end
    held     = out_valid && !out_ready;
    held_r.s = s; held_r.cout = cout; held_r.ovf = ovf;
    if (acc) q.push_back('{exp_next, cyc});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    int n = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    if (q.size() > 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic set_beat(input logic [15:0] x, input logic [15:0] y, input logic c, input logic sb, input res_t r);
    a = x; b = y; cin = c; sub = sb; exp_next = r;
    in_valid = 1'b1;
  endtask

  task automatic rand_beat();
    logic [15:0] x, y;
    logic c, sb;
    x = 16'($urandom); y = 16'($urandom); c = 1'($urandom); sb = 1'($urandom);
    set_beat(x, y, c, sb, model(x, y, c, sb));
  endtask

  task automatic reset_checks(input string tag);
    #1;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_s"}, {16'b0, s}, 32'd0);
    check({tag, "_cout"}, {31'b0, cout}, 32'd0);
    check({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
  endtask

  vec_t tab [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0}};
    tab[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    tab[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
    tab[3] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    tab[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    tab[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, '{16'h0001, 1'b1, 1'b0}};

    // Power-up reset
    @(negedge clk); @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    #1 check("release_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    // Table vectors, one at a time, latency checked
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_beat(tab[i].a, tab[i].b, tab[i].cin, tab[i].sub, tab[i].exp);
      cycle();
      check("tab_accept", {31'b0, acc}, 32'd1);
      drain(20);
    end

    // Throughput: 8 back-to-back beats, every output exactly NSEG cycles after its input
    for (int i = 0; i < 8; i++) begin
      set_beat(16'(i), 16'(i * 16'h1111), 1'b0, 1'b0, model(16'(i), 16'(i * 16'h1111), 1'b0, 1'b0));
      cycle();
      check("thr_in_ready", {31'b0, acc}, 32'd1);
    end
    drain(20);

    // Backpressure: stall after the first result while streaming, then release
    begin
      int  beats = 0, stall_cnt = 0;
      bit  stalled = 1'b0;
      chk_lat = 1'b0;
      rand_beat();
      for (int i = 0; i < 40; i++) begin
        cycle();
        if (acc) begin
          beats++;
          if (beats < 12) rand_beat(); else in_valid = 1'b0;
        end
        if (!stalled && out_valid) begin
          stalled   = 1'b1;
          out_ready = 1'b0;
        end else if (stalled && stall_cnt < 6) begin
          stall_cnt++;
          if (stall_cnt == 6) begin
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            out_ready = 1'b1;
          end
        end
      end
      check("bp_beats", beats, 12);
      drain(40);
    end

    // Random traffic with random backpressure
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) rand_beat();
        else begin
          in_valid = 1'b0;
          a = 16'($urandom); b = 16'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    out_ready = 1'b1;
    drain(40);

    // Reset with three beats in flight
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); cyc++; @(negedge clk);
    reset_checks("midrst");
    q.delete();
    held  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    set_beat(tab[0].a, tab[0].b, tab[0].cin, tab[0].sub, tab[0].exp);
    cycle();
    check("post_rst_accept", {31'b0, acc}, 32'd1);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
